// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector between two first-word-fall-through FIFOs.
// Two circular line buffers feed a 3x3 window; one output is produced per input after priming.
module sobel_stream #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAG_MODE   = 0,
    parameter int unsigned THRESH_EN  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned LB_DEPTH = IMG_WIDTH - 1;
    localparam int unsigned KW       = $clog2(NPIX + 1);
    localparam int unsigned RW       = $clog2(IMG_HEIGHT);
    localparam int unsigned CW       = $clog2(IMG_WIDTH);
    localparam int unsigned PW       = $clog2(LB_DEPTH);
    localparam int unsigned GW       = DATA_WIDTH + 4;
    localparam int unsigned AW       = DATA_WIDTH + 3;
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StFlush} state_e;

    state_e                state_q;
    logic [KW-1:0]         k_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [PW-1:0]         ptr_q;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] lb_a [LB_DEPTH];
    logic [DATA_WIDTH-1:0] lb_b [LB_DEPTH];
    logic [DATA_WIDTH-1:0] result_q;
    logic                  frame_done_q;

    logic [GW-1:0]         px [3][3];
    logic [GW-1:0]         gx, gy, sum, mag;
    logic [AW-1:0]         ax, ay;
    logic [DATA_WIDTH-1:0] sat, pix_calc;
    logic                  border, last_pos;
    logic [RW-1:0]         row_next;
    logic [CW-1:0]         col_next;

    assign in_rd_en   = (state_q == StRead) && !in_empty;
    assign out_wr_en  = ((state_q == StWrite) || (state_q == StFlush)) && !out_full;
    assign out_din    = ((state_q == StWrite) && !out_full) ? result_q : '0;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

    // Window row 2 is the newest image row, column 2 the newest pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px[r][c] = GW'(win_q[r][c]);
            end
        end
        gx = (px[0][2] + (px[1][2] << 1) + px[2][2]) - (px[0][0] + (px[1][0] << 1) + px[2][0]);
        gy = (px[2][0] + (px[2][1] << 1) + px[2][2]) - (px[0][0] + (px[0][1] << 1) + px[0][2]);
        ax = AW'(gx[GW-1] ? (~gx + GW'(1)) : gx);
        ay = AW'(gy[GW-1] ? (~gy + GW'(1)) : gy);
        sum = GW'(ax) + GW'(ay);
        if (MAG_MODE == 1) begin
            mag = (ax >= ay) ? GW'(ax) : GW'(ay);
        end else begin
            mag = sum >> 1;
        end
        sat = (mag > GW'(PIX_MAX)) ? PIX_MAX : mag[DATA_WIDTH-1:0];
        border = (row_q == '0) || (row_q == RW'(IMG_HEIGHT - 1)) ||
                 (col_q == '0) || (col_q == CW'(IMG_WIDTH - 1));
        if (border) begin
            pix_calc = '0;
        end else if (THRESH_EN == 1) begin
            pix_calc = (sat >= thresh) ? PIX_MAX : '0;
        end else begin
            pix_calc = sat;
        end
    end

    // Position of the next output pixel, advanced on every push.
    always_comb begin
        last_pos = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
        row_next = row_q;
        col_next = col_q + CW'(1);
        if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_next = '0;
            row_next = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            ptr_q        <= '0;
            result_q     <= '0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!in_empty) state_q <= StRead;
                end
                StRead: begin
                    if (!in_empty) begin
                        for (int r = 0; r < 3; r++) begin
                            win_q[r][0] <= win_q[r][1];
                            win_q[r][1] <= win_q[r][2];
                        end
                        win_q[2][2] <= in_dout;
                        win_q[1][2] <= lb_a[ptr_q];
                        win_q[0][2] <= lb_b[ptr_q];
                        ptr_q <= (ptr_q == PW'(LB_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
                        k_q   <= k_q + KW'(1);
                        if (k_q >= KW'(IMG_WIDTH + 1)) state_q <= StCalc;
                    end
                end
                StCalc: begin
                    result_q <= pix_calc;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    if (!out_full) begin
                        row_q   <= row_next;
                        col_q   <= col_next;
                        state_q <= (k_q == KW'(NPIX)) ? StFlush : StRead;
                    end
                end
                StFlush: begin
                    if (!out_full) begin
                        row_q <= row_next;
                        col_q <= col_next;
                        if (last_pos) begin
                            state_q      <= StIdle;
                            k_q          <= '0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Each buffer delays by IMG_WIDTH pops in total, counting the hop into the window.
    always_ff @(posedge clock) begin
        if (in_rd_en) begin
            lb_a[ptr_q] <= win_q[2][2];
            lb_b[ptr_q] <= win_q[1][2];
        end
    end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_WIDTH, 720: pixels per row; minimum 3.
- IMG_HEIGHT, 540: rows per frame; minimum 3.
- DATA_WIDTH, 8: bits per pixel, input and output.
- MAG_MODE, 0: 0 = (|Gx|+|Gy|)/2; 1 = max(|Gx|,|Gy|).
- THRESH_EN, 0: 1 = binarise the output against thresh.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: reset, asynchronous, active-high.
- in_rd_en, out, 1: pop request to the first-word-fall-through input FIFO.
- in_empty, in, 1: input FIFO empty.
- in_dout, in, DATA_WIDTH: input pixel; valid whenever in_empty=0.
- out_wr_en, out, 1: push request to the output FIFO.
- out_full, in, 1: output FIFO full.
- out_din, out, DATA_WIDTH: output pixel.
- thresh, in, DATA_WIDTH: binarisation level; sampled every cycle.
- busy, out, 1: a frame is in progress.
- frame_done, out, 1: one-cycle pulse after the last output of a frame.

Function
REQ-003 Pixels arrive in raster order, N = IMG_WIDTH*IMG_HEIGHT per frame. Exactly N outputs are produced per frame, in the same raster order.
REQ-004 Storage: two line buffers of IMG_WIDTH-1 entries each, plus a 3x3 window register. No full-frame or 2-row flat shift array.
REQ-005 FSM states and transitions:
- IDLE -> READ when in_empty=0.
- READ: when in_empty=0, assert in_rd_en for 1 cycle and shift the window and line buffers.
  - -> CALC once the input count k exceeds IMG_WIDTH+1.
  - Otherwise stay in READ.
  - When k==N after this pop -> CALC, then FLUSH.
- CALC (1 cycle): register the result -> WRITE.
- WRITE: hold until out_full=0, then assert out_wr_en for 1 cycle.
  - -> READ while k<N.
  - -> FLUSH when k==N.
- FLUSH: emit the IMG_WIDTH+1 trailing zero outputs, each one waiting on out_full=0 -> IDLE.
REQ-006 The output for centre index i=k-IMG_WIDTH-2 is computed when input k-1 (0-based) is the newest window pixel. The first IMG_WIDTH+1 pops produce no output.
REQ-007 Border pixels (row 0, row IMG_HEIGHT-1, column 0, column IMG_WIDTH-1) output 0 regardless of window contents and of THRESH_EN.
REQ-008 Gradient definitions, p[dr][dc] with dr,dc in {-1,0,1}:
- Gx = (p[-1][1]+2p[0][1]+p[1][1]) - (p[-1][-1]+2p[0][-1]+p[1][-1]).
- Gy = (p[1][-1]+2p[1][0]+p[1][1]) - (p[-1][-1]+2p[-1][0]+p[-1][1]).
REQ-009 Gx and Gy are signed, DATA_WIDTH+4 bits, with no intermediate overflow. Absolute values are unsigned, DATA_WIDTH+3 bits. The MAG_MODE sum uses DATA_WIDTH+4 bits; /2 truncates.
REQ-010 The magnitude saturates to 2^DATA_WIDTH-1.
REQ-011 When THRESH_EN=1: out_din = all ones if the saturated magnitude >= thresh, else 0.
REQ-012 out_din is 0 whenever out_wr_en=0.
REQ-013 in_rd_en is never asserted while in_empty=1 or outside READ. out_wr_en is never asserted while out_full=1.
REQ-014 busy=1 in every state except IDLE.
REQ-015 frame_done pulses in the cycle after the Nth out_wr_en. Row/column counters wrap to 0 at end of frame.
REQ-016 A new frame may begin in the cycle after frame_done. Line-buffer contents are not cleared; stale data is masked by REQ-007.
REQ-017 Stalls: in_empty=1 mid-frame holds all state. Backpressure (out_full=1) holds the WRITE result with no data loss or duplication.

Reset
REQ-018 While reset=1: state=IDLE; counters=0; window=0; in_rd_en, out_wr_en, out_din, busy and frame_done are all 0.
REQ-019 Reset mid-frame discards the partial frame. After release, the next input pixel is treated as pixel (0,0).

Verification
REQ-020 Bench parameters: IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=8. Directed scenarios:
- Flat frame, all 100 -> 48 outputs, all 0; one frame_done pulse.
- Vertical step: columns 0-3 = 0, columns 4-7 = 10, MAG_MODE=0 -> interior columns 3 and 4 output 20, all other outputs 0. Same frame with MAG_MODE=1 -> 40.
- Vertical step 0/255 -> edge outputs 255 (saturated). With THRESH_EN=1, thresh=30 and the 0/10 step: MAG_MODE=0 -> edge outputs 0; MAG_MODE=1 -> 255.
- Random out_full (50%) and random in_empty gaps -> the output sequence matches a golden model; no push while full; no pop while empty.
- Reset asserted after 20 pops, then a full flat frame -> 48 zero outputs; the partial frame leaves no trace.
- Two back-to-back frames with no gap -> 96 outputs, two frame_done pulses, with the second frame's row-1 outputs unaffected by first-frame data.
